// File: rtl/ib_fetch_aligner_pkg.sv
// Shared constants and types for the instruction-buffer fetch aligner.
// The entry layout is {exc, rvc, pc, instr}, with the instruction word in the low bits.
package ib_fetch_aligner_pkg;

    localparam int FETCH_RATE_HW = 8;
    localparam int VA_LEN        = 39;
    localparam int IB_DEPTH      = 32;
    localparam int ENTRY_LEN     = VA_LEN + 34;

    localparam int IB_INSTR_LSB  = 0;
    localparam int IB_PC_LSB     = 32;
    localparam int IB_RVC_BIT    = VA_LEN + 32;
    localparam int IB_EXC_BIT    = VA_LEN + 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } align_state_t;

endpackage

// File: rtl/fetch_hw_scan.sv
// Combinational scan of one fetch packet: finds where instructions start,
// which of them are 32-bit, whether a 32-bit low half is left over at the end,
// and how many buffer entries the packet produces.
module fetch_hw_scan
    import ib_fetch_aligner_pkg::*;
#(
    parameter int FETCH_HW = FETCH_RATE_HW
) (
    input  logic [FETCH_HW-1:0]         is_wide,
    input  logic [$clog2(FETCH_HW)-1:0] offset,
    input  logic                        pend,
    output logic [FETCH_HW-1:0]         start_mask,
    output logic [FETCH_HW-1:0]         wide_mask,
    output logic                        trail,
    output logic [$clog2(FETCH_HW):0]   count
);

    localparam int NW = $clog2(FETCH_HW) + 1;

    logic skip;

    // Walk the halfwords from the offset; a pending low half makes the first one a high half.
    always_comb begin
        start_mask = '0;
        wide_mask  = '0;
        trail      = 1'b0;
        count      = '0;
        skip       = 1'b0;
        for (int k = 0; k < FETCH_HW; k++) begin
            if (k >= int'(offset)) begin
                if (skip) begin
                    skip = 1'b0;
                end else if (pend && (k == int'(offset))) begin
                    start_mask[k] = 1'b1;
                    wide_mask[k]  = 1'b1;
                    count         = count + NW'(1);
                end else if (is_wide[k]) begin
                    if (k == FETCH_HW - 1) begin
                        trail = 1'b1;
                    end else begin
                        start_mask[k] = 1'b1;
                        wide_mask[k]  = 1'b1;
                        count         = count + NW'(1);
                        skip          = 1'b1;
                    end
                end else begin
                    start_mask[k] = 1'b1;
                    count         = count + NW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ib_fetch_aligner.sv
// Fetch-packet aligner in front of the instruction buffer. Splits a packet into
// 16/32-bit instructions, carries a straddling low half across packets, admits a
// packet only when every entry it makes fits, and registers the buffer write ports.
module ib_fetch_aligner
    import ib_fetch_aligner_pkg::*;
#(
    parameter int FETCH_HW  = FETCH_RATE_HW,
    parameter int VA_LEN    = ib_fetch_aligner_pkg::VA_LEN,
    parameter int ENTRY_LEN = VA_LEN + 34,
    parameter int IB_DEPTH  = ib_fetch_aligner_pkg::IB_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Flush,
    input  logic                          FetchValid,
    output logic                          FetchReady,
    input  logic [16*FETCH_HW-1:0]        FetchData,
    input  logic [VA_LEN-1:0]             FetchPC,
    input  logic                          FetchFault,
    input  logic [$clog2(IB_DEPTH):0]     IbFreeCnt,
    output logic [FETCH_HW-1:0]           IbWriteEnable,
    output logic [FETCH_HW*ENTRY_LEN-1:0] IbDataIn
);

    localparam int OW = $clog2(FETCH_HW);
    localparam int NW = OW + 1;
    localparam int CW = $clog2(IB_DEPTH) + 2;

    align_state_t                  state_q;
    logic [15:0]                   pend_hw_q;
    logic [VA_LEN-1:0]             pend_pc_q;
    logic                          pend_flt_q;
    logic [FETCH_HW-1:0]           we_q;
    logic [FETCH_HW*ENTRY_LEN-1:0] data_q;

    logic [15:0]                   hw [FETCH_HW];
    logic [FETCH_HW-1:0]           is_wide;
    logic [OW-1:0]                 offset;
    logic                          cont;
    logic [FETCH_HW-1:0]           start_mask;
    logic [FETCH_HW-1:0]           wide_mask;
    logic                          trail;
    logic [NW-1:0]                 scan_count;
    logic [NW-1:0]                 n_eff;
    logic [NW-1:0]                 inflight;
    logic [CW-1:0]                 need;
    logic                          room;
    logic                          accept;
    logic [FETCH_HW-1:0]           next_we;
    logic [FETCH_HW*ENTRY_LEN-1:0] next_data;
    logic [VA_LEN-1:0]             hw_pc;
    logic [ENTRY_LEN-1:0]          entry;
    logic [NW-1:0]                 slot;

    assign offset = FetchPC[OW:1];
    assign cont   = (state_q == ST_PEND) && (FetchPC == pend_pc_q + VA_LEN'(2));

    // Break the packet into halfwords and flag the ones that open a 32-bit instruction.
    always_comb begin
        for (int k = 0; k < FETCH_HW; k++) begin
            hw[k]      = FetchData[16*k +: 16];
            is_wide[k] = (hw[k][1:0] == 2'b11);
        end
    end

    fetch_hw_scan #(
        .FETCH_HW (FETCH_HW)
    ) u_scan (
        .is_wide    (is_wide),
        .offset     (offset),
        .pend       (cont),
        .start_mask (start_mask),
        .wide_mask  (wide_mask),
        .trail      (trail),
        .count      (scan_count)
    );

    // Entries still sitting on the write ports have not been debited from the free count yet.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < FETCH_HW; i++) begin
            inflight = inflight + NW'(we_q[i]);
        end
    end

    assign n_eff      = FetchFault ? NW'(1) : scan_count;
    assign need       = CW'(n_eff) + CW'(inflight);
    assign room       = (need <= CW'(IbFreeCnt));
    assign FetchReady = rst && !Flush && (state_q != ST_HALT) && room;
    assign accept     = FetchValid && FetchReady;

    // Pack the instruction starts onto the lowest write ports in program order.
    always_comb begin
        next_data = '0;
        next_we   = '0;
        slot      = '0;
        hw_pc     = '0;
        entry     = '0;
        for (int k = 0; k < FETCH_HW; k++) begin
            hw_pc = {FetchPC[VA_LEN-1:OW+1], OW'(k), 1'b0};
            if (cont && (k == int'(offset))) begin
                entry = {pend_flt_q, 1'b0, pend_pc_q, hw[k], pend_hw_q};
            end else if (wide_mask[k]) begin
                entry = {1'b0, 1'b0, hw_pc, hw[(k + 1) % FETCH_HW], hw[k]};
            end else begin
                entry = {1'b0, 1'b1, hw_pc, 16'h0000, hw[k]};
            end
            if (start_mask[k]) begin
                next_data[slot*ENTRY_LEN +: ENTRY_LEN] = entry;
                slot = slot + NW'(1);
            end
        end
        if (FetchFault) begin
            next_data = '0;
            next_data[ENTRY_LEN-1:0] = {1'b1, 1'b0, (cont ? pend_pc_q : FetchPC), 32'h0};
        end
        for (int i = 0; i < FETCH_HW; i++) begin
            next_we[i] = (NW'(i) < n_eff);
        end
    end

    // Carry state and the output stage; flush wins over any accept in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            pend_hw_q  <= '0;
            pend_pc_q  <= '0;
            pend_flt_q <= 1'b0;
            we_q       <= '0;
            data_q     <= '0;
        end else if (Flush) begin
            state_q    <= ST_IDLE;
            pend_hw_q  <= '0;
            pend_pc_q  <= '0;
            pend_flt_q <= 1'b0;
            we_q       <= '0;
            data_q     <= '0;
        end else if (accept) begin
            we_q   <= next_we;
            data_q <= next_data;
            if (FetchFault) begin
                state_q    <= ST_HALT;
                pend_hw_q  <= '0;
                pend_pc_q  <= '0;
                pend_flt_q <= 1'b0;
            end else if (trail) begin
                state_q    <= ST_PEND;
                pend_hw_q  <= hw[FETCH_HW-1];
                pend_pc_q  <= {FetchPC[VA_LEN-1:OW+1], OW'(FETCH_HW - 1), 1'b0};
                pend_flt_q <= FetchFault;
            end else begin
                state_q    <= ST_IDLE;
                pend_hw_q  <= '0;
                pend_pc_q  <= '0;
                pend_flt_q <= 1'b0;
            end
        end else begin
            we_q   <= '0;
            data_q <= '0;
        end
    end

    assign IbWriteEnable = we_q;
    assign IbDataIn      = data_q;

endmodule
